color_to_grayscale: RTL and testbench

Row-parallel RGB-to-grayscale converter for the image-processing datapath. Each clock it accepts one full image row of SIZE pixels, given as three 8-bit colour-plane arrays. It produces the matching row of 8-bit luminance values through a fixed three-register pipeline. It has no handshake: a new row is taken every cycle, and the caller tracks row alignment by latency.

---
 rtl/color_to_grayscale.sv | 52 +++++
 tb/tb_color_to_grayscale.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/color_to_grayscale.sv
// Row-parallel RGB-to-grayscale converter: SIZE independent lanes, each computing
// (77*R + 150*G + 29*B) >> 8 through a three-register pipeline.
module color_to_grayscale #(
  parameter int SIZE = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] R_arr_in     [SIZE-1:0],
  input  logic [7:0] G_arr_in     [SIZE-1:0],
  input  logic [7:0] B_arr_in     [SIZE-1:0],
  output logic [7:0] gray_arr_out [SIZE-1:0]
);

  localparam logic [15:0] W_R = 16'd77;
  localparam logic [15:0] W_G = 16'd150;
  localparam logic [15:0] W_B = 16'd29;

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [7:0]  r_q, g_q, b_q;
    logic [15:0] r_prod_q, g_prod_q, b_prod_q;
    logic [15:0] sum;
    logic [7:0]  gray_q;

    // Weights sum to 256, so the 16-bit sum peaks at 65280 and never wraps.
    assign sum = r_prod_q + g_prod_q + b_prod_q;

    // NOTE: every pipeline register uses <= so all stages sample the previous
    // stage's old value on the same edge; each is also cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q      <= '0;
        g_q      <= '0;
        b_q      <= '0;
        r_prod_q <= '0;
        g_prod_q <= '0;
        b_prod_q <= '0;
        gray_q   <= '0;
      end else begin
        r_q      <= R_arr_in[k];
        g_q      <= G_arr_in[k];
        b_q      <= B_arr_in[k];
        r_prod_q <= 16'(r_q) * W_R;
        g_prod_q <= 16'(g_q) * W_G;
        b_prod_q <= 16'(b_q) * W_B;
        gray_q   <= 8'(sum >> 8);
      end
    end

    assign gray_arr_out[k] = gray_q;
  end

endmodule

// File: tb/tb_color_to_grayscale.sv
// Self-checking bench for color_to_grayscale: reset behaviour, pure-colour vectors,
// latency/ordering, lane independence and a random 100-row image against a model.
module tb_color_to_grayscale;

  localparam int SIZE = 100;

  typedef logic [SIZE-1:0][7:0] row_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       tb_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] r_in    [SIZE-1:0];
  logic [7:0] g_in    [SIZE-1:0];
  logic [7:0] b_in    [SIZE-1:0];
  logic [7:0] gray_out[SIZE-1:0];

  int checks   = 0;
  int failures = 0;

  row_t exp_q[$];

  color_to_grayscale #(.SIZE(SIZE)) dut (
    .clk          (tb_clk),
    .rst_n        (rst_n),
    .R_arr_in     (r_in),
    .G_arr_in     (g_in),
    .B_arr_in     (b_in),
    .gray_arr_out (gray_out)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Compares a whole output row; reports the first differing lane.
  task automatic check_row(input string name, input row_t exp);
    int lane = 0;
    for (int k = SIZE - 1; k >= 0; k--)
      if (gray_out[k] !== exp[k]) lane = k;
    check($sformatf("%s lane %0d", name, lane), int'(gray_out[lane]), int'(exp[lane]));
  endtask

  function automatic row_t model(input row_t r, input row_t g, input row_t b);
    row_t res;
    for (int k = 0; k < SIZE; k++) begin
      int lum = (77 * int'(r[k]) + 150 * int'(g[k]) + 29 * int'(b[k])) / 256;
      res[k] = 8'(lum);
    end
    return res;
  endfunction

  function automatic row_t fill(input logic [7:0] v);
    row_t res;
    for (int k = 0; k < SIZE; k++) res[k] = v;
    return res;
  endfunction

  task automatic drive(input row_t r, input row_t g, input row_t b);
    for (int k = 0; k < SIZE; k++) begin
      r_in[k] = r[k];
      g_in[k] = g[k];
      b_in[k] = b[k];
    end
  endtask

  // Advance one clock; return on the following falling edge (the sampling point).
  task automatic step();
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  // Drive one row per cycle and compare each output three samples later.
  task automatic stream_row(input string name, input row_t r, input row_t g, input row_t b);
    drive(r, g, b);
    exp_q.push_back(model(r, g, b));
    step();
    if (exp_q.size() == 3) check_row(name, exp_q.pop_front());
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      step();
      check_row(name, exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t vecs[7];
    row_t r, g, b;

    vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, "white"};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'h4C, "red"};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h95, "green"};
    vecs[3] = '{8'h00, 8'h00, 8'hFF, 8'h1C, "blue"};
    vecs[4] = '{8'd200, 8'd100, 8'd50, 8'd124, "mixed"};
    vecs[5] = '{8'd100, 8'd100, 8'd100, 8'd100, "neutral"};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00, "black"};

    // Reset held while the clock runs with non-zero inputs.
    drive(fill(8'hFF), fill(8'hFF), fill(8'hFF));
    repeat (4) step();
    check_row("reset_hold", fill(8'h00));
    rst_n = 1'b1;

    // Table-driven pure/mixed colours, each held for three edges.
    foreach (vecs[i]) begin
      drive(fill(vecs[i].r), fill(vecs[i].g), fill(vecs[i].b));
      repeat (3) step();
      check_row(vecs[i].name, fill(vecs[i].exp));
    end

    // Asynchronous reset mid-stream clears output between edges.
    drive(fill(8'd100), fill(8'd100), fill(8'd100));
    repeat (3) step();
    check_row("pre_reset", fill(8'd100));
    @(posedge tb_clk);
    #2 rst_n = 1'b0;
    #1 check_row("async_clear", fill(8'h00));
    step();
    check_row("reset_held", fill(8'h00));
    rst_n = 1'b1;
    step();
    check_row("post_reset_n", fill(8'h00));
    step();
    check_row("post_reset_n1", fill(8'h00));
    step();
    check_row("post_reset_n2", fill(8'd100));

    // Latency and ordering: rows 10, 20, 30 on consecutive edges.
    drive(fill(8'd10), fill(8'd10), fill(8'd10));
    step();
    drive(fill(8'd20), fill(8'd20), fill(8'd20));
    step();
    drive(fill(8'd30), fill(8'd30), fill(8'd30));
    step();
    check_row("latency_n2", fill(8'd10));
    step();
    check_row("latency_n3", fill(8'd20));
    step();
    check_row("latency_n4", fill(8'd30));

    // Lane independence: lane k carries k on every plane.
    for (int k = 0; k < SIZE; k++) r[k] = 8'(k % 256);
    drive(r, r, r);
    repeat (3) step();
    check_row("lane_index", r);

    // One lane toggling FF/00 must not disturb its neighbours.
    for (int c = 0; c < 20; c++) begin
      g = r;
      g[5] = (c % 2 == 0) ? 8'hFF : 8'h00;
      stream_row("leakage", g, g, g);
    end
    drain("leakage");

    // Random 100x100 image streamed back-to-back.
    for (int row = 0; row < 100; row++) begin
      for (int k = 0; k < SIZE; k++) begin
        r[k] = 8'($urandom_range(255));
        g[k] = 8'($urandom_range(255));
        b[k] = 8'($urandom_range(255));
      end
      stream_row($sformatf("image row %0d", row), r, g, b);
    end
    drain("image tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
